// File: rtl/vm_pkg.sv
// Shared types for the vending transaction controller: FSM states, coin encoding,
// money width and the coin denomination lookup.
package vm_pkg;

  typedef logic [7:0] money_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } vm_state_t;

  typedef enum logic [1:0] {
    COIN_5  = 2'd0,
    COIN_10 = 2'd1,
    COIN_20 = 2'd2,
    COIN_50 = 2'd3
  } coin_t;

  function automatic money_t coin_value(input coin_t c);
    money_t v;
    case (c)
      COIN_5:  v = 8'd5;
      COIN_10: v = 8'd10;
      COIN_20: v = 8'd20;
      COIN_50: v = 8'd50;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vending_txn_ctrl_if.sv
// Coin/purchase request bus into the transaction controller and the dispense/refund
// signals it drives toward output_handler. slave = controller side, master = requester side.
interface vending_txn_ctrl_if;
  import vm_pkg::*;

  logic       coin_valid;
  logic [1:0] coin_type;
  logic       buy_valid;
  logic [1:0] buy_sel;
  logic       cancel;

  logic       end_trans;
  money_t     sum_money;
  money_t     price;
  logic [1:0] item_select;
  logic       refund_valid;
  money_t     refund_amount;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;

  modport master (
    output coin_valid, coin_type, buy_valid, buy_sel, cancel,
    input  end_trans, sum_money, price, item_select, refund_valid,
           refund_amount, coin_reject, insufficient, busy
  );

  modport slave (
    input  coin_valid, coin_type, buy_valid, buy_sel, cancel,
    output end_trans, sum_money, price, item_select, refund_valid,
           refund_amount, coin_reject, insufficient, busy
  );

endinterface

// File: rtl/vm_credit_acc.sv
// Credit register: adds accepted coins, refuses coins that would pass 255 or arrive
// while the controller cannot take them, and pulses coin_reject the following cycle.
module vm_credit_acc
  import vm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_type_i,
  input  logic       coin_allow_i,
  input  logic       clear_i,
  output money_t     sum_money_o,
  output logic       coin_accept_o,
  output logic       coin_reject_o
);

  money_t     sum_q, sum_d;
  logic       reject_q, reject_d;
  logic       accept;
  logic [8:0] sum_wide;

  // The ninth bit of the widened sum flags a coin that would overflow the credit.
  assign sum_wide = {1'b0, sum_q} + {1'b0, coin_value(coin_t'(coin_type_i))};
  assign accept   = coin_valid_i && coin_allow_i && !sum_wide[8];
  assign reject_d = coin_valid_i && !accept;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_wide[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      reject_q <= reject_d;
    end
  end

  assign sum_money_o   = sum_q;
  assign coin_accept_o = accept;
  assign coin_reject_o = reject_q;

endmodule

// File: rtl/vending_txn_ctrl.sv
// Vending transaction sequencer: collects credit, arbitrates buy/cancel, holds the dispense
// strobe for DISP_HOLD cycles. Optional idle auto-refund is enabled by defining VM_TIMEOUT_EN.
module vending_txn_ctrl
  import vm_pkg::*;
#(
  parameter money_t PRICE_0   = 8'd15,
  parameter money_t PRICE_1   = 8'd20,
  parameter money_t PRICE_2   = 8'd25,
  parameter money_t PRICE_3   = 8'd40,
  parameter int     DISP_HOLD = 2
`ifdef VM_TIMEOUT_EN
  ,
  parameter int     TIMEOUT_CYCLES = 1000
`endif
) (
  input logic               clk,
  input logic               rst_n,
  vending_txn_ctrl_if.slave bus
);

  localparam int HOLD_W = $clog2(DISP_HOLD + 1);

  vm_state_t         state_q;
  logic              end_trans_q;
  money_t            price_q;
  logic [1:0]        item_q;
  logic              refund_valid_q;
  money_t            refund_amount_q;
  logic              insufficient_q;
  logic              busy_q;
  logic [HOLD_W-1:0] hold_q;

  money_t sum_money;
  money_t sel_price;
  logic   coin_accept;
  logic   coin_allow;
  logic   credit_clear;
  logic   refund_req;
  logic   hold_last;
  logic   buy_ok;

  function automatic money_t price_of(input logic [1:0] sel);
    money_t p;
    case (sel)
      2'd0:    p = PRICE_0;
      2'd1:    p = PRICE_1;
      2'd2:    p = PRICE_2;
      default: p = PRICE_3;
    endcase
    return p;
  endfunction

  assign sel_price    = price_of(bus.buy_sel);
  assign buy_ok       = (sum_money >= sel_price);
  assign hold_last    = (hold_q == HOLD_W'(DISP_HOLD));
  // A cancel in COLLECT wins over a same-cycle coin, so that coin goes back uncredited.
  assign coin_allow   = (state_q == IDLE) || ((state_q == COLLECT) && !refund_req);
  assign credit_clear = ((state_q == DISPENSE) && hold_last) || (state_q == REFUND);

`ifdef VM_TIMEOUT_EN
  logic [15:0] idle_q;
  logic        activity;
  logic        timeout_hit;

  assign activity    = bus.coin_valid || bus.buy_valid || bus.cancel;
  assign timeout_hit = (state_q == COLLECT) && !activity
                       && (idle_q == 16'(TIMEOUT_CYCLES - 1));
  assign refund_req  = bus.cancel || timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if ((state_q != COLLECT) || activity) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 16'd1;
    end
  end
`else
  assign refund_req = bus.cancel;
`endif

  vm_credit_acc u_credit (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_valid_i  (bus.coin_valid),
    .coin_type_i   (bus.coin_type),
    .coin_allow_i  (coin_allow),
    .clear_i       (credit_clear),
    .sum_money_o   (sum_money),
    .coin_accept_o (coin_accept),
    .coin_reject_o (bus.coin_reject)
  );

  // Buy decisions use the credit registered before this cycle's coin lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      end_trans_q     <= 1'b0;
      price_q         <= '0;
      item_q          <= '0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
      insufficient_q  <= 1'b0;
      busy_q          <= 1'b0;
      hold_q          <= '0;
    end else begin
      insufficient_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.buy_valid) begin
            insufficient_q <= 1'b1;
          end
          if (coin_accept) begin
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (refund_req) begin
            state_q         <= REFUND;
            refund_valid_q  <= 1'b1;
            refund_amount_q <= sum_money;
            busy_q          <= 1'b1;
          end else if (bus.buy_valid) begin
            if (buy_ok) begin
              state_q     <= DISPENSE;
              end_trans_q <= 1'b1;
              price_q     <= sel_price;
              item_q      <= bus.buy_sel;
              busy_q      <= 1'b1;
              hold_q      <= HOLD_W'(1);
            end else begin
              insufficient_q <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          if (hold_last) begin
            state_q     <= IDLE;
            end_trans_q <= 1'b0;
            price_q     <= '0;
            item_q      <= '0;
            busy_q      <= 1'b0;
            hold_q      <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        REFUND: begin
          state_q         <= IDLE;
          refund_valid_q  <= 1'b0;
          refund_amount_q <= '0;
          busy_q          <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.end_trans     = end_trans_q;
  assign bus.sum_money     = sum_money;
  assign bus.price         = price_q;
  assign bus.item_select   = item_q;
  assign bus.refund_valid  = refund_valid_q;
  assign bus.refund_amount = refund_amount_q;
  assign bus.insufficient  = insufficient_q;
  assign bus.busy          = busy_q;

endmodule
